// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, 2-flop row sync, frame-level debounce, one-cycle key events.
// Optional auto-repeat while a key is held is built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV        = 16'd50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 25,
    parameter int unsigned REPEAT_RATE     = 5
`endif
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] KEY_ROW,
    output logic [3:0] KEY_COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    output logic       KEY_HELD
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONFIRM = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [3:0] DB_FRAMES = 4'(DEBOUNCE_FRAMES);

    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] slot_q, slot_d;
    logic [1:0]  col_q, col_d;
    logic [3:0]  col_drv_q, col_drv_d;
    logic [1:0]  acc_n_q, acc_n_d;
    logic [3:0]  acc_key_q, acc_key_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  cand_q, cand_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;

    logic        slot_end, frame_end;
    logic [3:0]  hits;
    logic [1:0]  col_n;
    logic [1:0]  row_idx;
    logic [1:0]  sum_n;
    logic [3:0]  sum_key;
    logic [3:0]  cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] RPT_DELAY = 8'(REPEAT_DELAY);
    localparam logic [7:0] RPT_RATE  = 8'(REPEAT_RATE);
    logic [7:0] rep_q, rep_d;
    logic [7:0] rate_q, rate_d;
`endif

    // Column strobe timing
    always_comb begin
        slot_end  = (slot_q == SCAN_DIV - 16'd1);
        frame_end = slot_end && (col_q == 2'd3);
        slot_d    = slot_end ? '0 : slot_q + 16'd1;
        col_d     = slot_end ? col_q + 2'd1 : col_q;
        col_drv_d = ~(4'b0001 << col_d);
    end

    // Closure count for the current column (saturates at 2 = MULTI), merged into the frame accumulator
    always_comb begin
        hits    = ~row_sync_q;
        col_n   = 2'd0;
        row_idx = 2'd0;
        for (int unsigned r = 0; r < 4; r++) begin
            if (hits[r]) begin
                col_n   = (col_n == 2'd2) ? 2'd2 : col_n + 2'd1;
                row_idx = 2'(r);
            end
        end
        if (acc_n_q == 2'd0) begin
            sum_n   = col_n;
            sum_key = {row_idx, col_q};
        end else if (col_n == 2'd0) begin
            sum_n   = acc_n_q;
            sum_key = acc_key_q;
        end else begin
            sum_n   = 2'd2;
            sum_key = acc_key_q;
        end
        acc_n_d   = acc_n_q;
        acc_key_d = acc_key_q;
        if (slot_end) begin
            acc_n_d   = frame_end ? 2'd0 : sum_n;
            acc_key_d = frame_end ? 4'd0 : sum_key;
        end
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (sum_n == 2'd1) begin
                        cand_d  = sum_key;
                        cnt_d   = 4'd1;
                        state_d = ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (sum_n == 2'd1) begin
                        if (sum_key == cand_q) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc >= DB_FRAMES) begin
                                code_d  = cand_q;
                                valid_d = 1'b1;
                                cnt_d   = 4'd0;
                                state_d = ST_HELD;
                            end
                        end else begin
                            cand_d = sum_key;
                            cnt_d  = 4'd1;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_IDLE;
                    end
                end
                ST_HELD: begin
                    if (sum_n == 2'd0) begin
                        cnt_d   = 4'd1;
                        state_d = ST_RELEASE;
                    end
                end
                default: begin
                    if (sum_n == 2'd0) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc >= DB_FRAMES) begin
                            cnt_d   = 4'd0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_HELD;
                    end
                end
            endcase
        end
`ifdef KEYPAD_REPEAT_EN
        // Repeat counters run only across frames that both start and stay in HELD
        rep_d  = rep_q;
        rate_d = rate_q;
        if (state_d != ST_HELD || state_q != ST_HELD) begin
            rep_d  = '0;
            rate_d = '0;
        end else if (frame_end) begin
            if (rep_q != RPT_DELAY) begin
                rep_d = rep_q + 8'd1;
                if (rep_d == RPT_DELAY) begin
                    valid_d = 1'b1;
                end
            end else begin
                rate_d = rate_q + 8'd1;
                if (rate_d == RPT_RATE) begin
                    valid_d = 1'b1;
                    rate_d  = '0;
                end
            end
        end
`endif
        held_d = (state_d == ST_HELD) || (state_d == ST_RELEASE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            slot_q     <= '0;
            col_q      <= '0;
            col_drv_q  <= 4'b1110;
            acc_n_q    <= '0;
            acc_key_q  <= '0;
            state_q    <= ST_IDLE;
            cand_q     <= '0;
            cnt_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            row_meta_q <= KEY_ROW;
            row_sync_q <= row_meta_q;
            slot_q     <= slot_d;
            col_q      <= col_d;
            col_drv_q  <= col_drv_d;
            acc_n_q    <= acc_n_d;
            acc_key_q  <= acc_key_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            held_q     <= held_d;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rep_q  <= '0;
            rate_q <= '0;
        end else begin
            rep_q  <= rep_d;
            rate_q <= rate_d;
        end
    end
`endif

    assign KEY_COL   = col_drv_q;
    assign KEY_CODE  = code_q;
    assign KEY_VALID = valid_q;
    assign KEY_HELD  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 key-matrix model (SCAN_DIV=4, 3 debounce frames).
module tb_keypad_scanner;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] KEY_ROW;
    logic [3:0] KEY_COL;
    logic [3:0] KEY_CODE;
    logic       KEY_VALID;
    logic       KEY_HELD;

    logic [15:0] keys = '0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcount = 0;

    keypad_scanner #(
        .SCAN_DIV(16'd4),
        .DEBOUNCE_FRAMES(3)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DELAY(5),
        .REPEAT_RATE(2)
`endif
    ) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .KEY_ROW(KEY_ROW),
        .KEY_COL(KEY_COL),
        .KEY_CODE(KEY_CODE),
        .KEY_VALID(KEY_VALID),
        .KEY_HELD(KEY_HELD)
    );

    always #5 CLK = ~CLK;

    // A closed key pulls its row low only while its column is driven low
    always_comb begin
        KEY_ROW = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !KEY_COL[c]) KEY_ROW[r] = 1'b0;
            end
        end
    end

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    always @(negedge CLK) begin
        if (KEY_VALID === 1'b1) vcount <= vcount + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_cyc(input int t);
        int guard;
        guard = 0;
        while (cyc < t && guard < 100000) begin
            @(negedge CLK);
            guard++;
        end
        checks++;
        if (cyc !== t) begin
            errors++;
            $display("FAIL wait_cyc got %0d exp %0d", cyc, t);
        end
    endtask

    task automatic align_frame;
        @(negedge CLK);
        while (cyc % 16 != 0) @(negedge CLK);
    endtask

    task automatic test_reset;
        keys = '0;
        RESET_N = 1'b0;
        tick(3);
        checks++; if (KEY_COL !== 4'b1110) begin errors++; $display("FAIL reset_col got %b exp 1110", KEY_COL); end
        checks++; if (KEY_CODE !== 4'd0) begin errors++; $display("FAIL reset_code got %0d exp 0", KEY_CODE); end
        checks++; if (KEY_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", KEY_VALID); end
        checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL reset_held got %b exp 0", KEY_HELD); end
        RESET_N = 1'b1;
        wait_cyc(3);
        checks++; if (KEY_COL !== 4'b1110) begin errors++; $display("FAIL col_slot0 got %b exp 1110", KEY_COL); end
        wait_cyc(4);
        checks++; if (KEY_COL !== 4'b1101) begin errors++; $display("FAIL col_slot1 got %b exp 1101", KEY_COL); end
        wait_cyc(12);
        checks++; if (KEY_COL !== 4'b0111) begin errors++; $display("FAIL col_slot3 got %b exp 0111", KEY_COL); end
        wait_cyc(16);
        checks++; if (KEY_COL !== 4'b1110) begin errors++; $display("FAIL col_wrap got %b exp 1110", KEY_COL); end
    endtask

    task automatic test_clean_press;
        int f, r, base;
        align_frame;
        f = cyc;
        base = vcount;
        keys = 16'h0200;
        wait_cyc(f + 47);
        checks++; if (KEY_VALID !== 1'b0) begin errors++; $display("FAIL press_early got %b exp 0", KEY_VALID); end
        wait_cyc(f + 48);
        checks++; if (KEY_VALID !== 1'b1) begin errors++; $display("FAIL press_valid got %b exp 1", KEY_VALID); end
        checks++; if (KEY_CODE !== 4'd9) begin errors++; $display("FAIL press_code got %0d exp 9", KEY_CODE); end
        checks++; if (KEY_HELD !== 1'b1) begin errors++; $display("FAIL press_held got %b exp 1", KEY_HELD); end
        wait_cyc(f + 49);
        checks++; if (KEY_VALID !== 1'b0) begin errors++; $display("FAIL press_width got %b exp 0", KEY_VALID); end
        wait_cyc(f + 160);
        checks++; if (vcount - base !== 1) begin errors++; $display("FAIL press_count got %0d exp 1", vcount - base); end
        r = cyc;
        keys = '0;
        wait_cyc(r + 47);
        checks++; if (KEY_HELD !== 1'b1) begin errors++; $display("FAIL release_early got %b exp 1", KEY_HELD); end
        wait_cyc(r + 48);
        checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL release_held got %b exp 0", KEY_HELD); end
        checks++; if (KEY_CODE !== 4'd9) begin errors++; $display("FAIL release_code got %0d exp 9", KEY_CODE); end
        checks++; if (vcount - base !== 1) begin errors++; $display("FAIL release_count got %0d exp 1", vcount - base); end
    endtask

    task automatic test_bounce;
        int base;
        base = vcount;
        for (int i = 0; i < 4; i++) begin
            keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
            tick(20);
        end
        checks++; if (vcount - base !== 0) begin errors++; $display("FAIL bounce_none got %0d exp 0", vcount - base); end
        keys = 16'h0040;
        tick(80);
        checks++; if (vcount - base !== 1) begin errors++; $display("FAIL bounce_count got %0d exp 1", vcount - base); end
        checks++; if (KEY_CODE !== 4'd6) begin errors++; $display("FAIL bounce_code got %0d exp 6", KEY_CODE); end
        keys = '0;
        tick(80);
        checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL bounce_release got %b exp 0", KEY_HELD); end
    endtask

    task automatic test_multi;
        int base;
        base = vcount;
        keys = 16'h0041;
        tick(160);
        checks++; if (vcount - base !== 0) begin errors++; $display("FAIL multi_count got %0d exp 0", vcount - base); end
        checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL multi_held got %b exp 0", KEY_HELD); end
        keys = '0;
        tick(32);
        keys = 16'h0020;
        tick(80);
        checks++; if (vcount - base !== 1) begin errors++; $display("FAIL key5_count got %0d exp 1", vcount - base); end
        checks++; if (KEY_CODE !== 4'd5) begin errors++; $display("FAIL key5_code got %0d exp 5", KEY_CODE); end
        keys = 16'h0021;
        tick(80);
        checks++; if (vcount - base !== 1) begin errors++; $display("FAIL rollover_count got %0d exp 1", vcount - base); end
        checks++; if (KEY_CODE !== 4'd5) begin errors++; $display("FAIL rollover_code got %0d exp 5", KEY_CODE); end
        checks++; if (KEY_HELD !== 1'b1) begin errors++; $display("FAIL rollover_held got %b exp 1", KEY_HELD); end
        keys = '0;
        tick(80);
        checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL multi_release got %b exp 0", KEY_HELD); end
    endtask

    task automatic test_reset_mid_confirm;
        int f, base;
        align_frame;
        f = cyc;
        keys = 16'h0200;
        wait_cyc(f + 36);
        RESET_N = 1'b0;
        #1;
        checks++; if (KEY_COL !== 4'b1110) begin errors++; $display("FAIL midrst_col got %b exp 1110", KEY_COL); end
        checks++; if (KEY_CODE !== 4'd0) begin errors++; $display("FAIL midrst_code got %0d exp 0", KEY_CODE); end
        checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL midrst_held got %b exp 0", KEY_HELD); end
        tick(2);
        base = vcount;
        RESET_N = 1'b1;
        wait_cyc(47);
        checks++; if (KEY_VALID !== 1'b0) begin errors++; $display("FAIL midrst_early got %b exp 0", KEY_VALID); end
        checks++; if (vcount - base !== 0) begin errors++; $display("FAIL midrst_none got %0d exp 0", vcount - base); end
        wait_cyc(48);
        checks++; if (KEY_VALID !== 1'b1) begin errors++; $display("FAIL midrst_valid got %b exp 1", KEY_VALID); end
        checks++; if (KEY_CODE !== 4'd9) begin errors++; $display("FAIL midrst_code9 got %0d exp 9", KEY_CODE); end
        keys = '0;
        tick(80);
        checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL midrst_release got %b exp 0", KEY_HELD); end
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat;
        int f, base;
        align_frame;
        f = cyc;
        base = vcount;
        keys = 16'h0200;
        wait_cyc(f + 127);
        checks++; if (KEY_VALID !== 1'b0) begin errors++; $display("FAIL repeat_early got %b exp 0", KEY_VALID); end
        wait_cyc(f + 128);
        checks++; if (KEY_VALID !== 1'b1) begin errors++; $display("FAIL repeat_first got %b exp 1", KEY_VALID); end
        checks++; if (KEY_CODE !== 4'd9) begin errors++; $display("FAIL repeat_code got %0d exp 9", KEY_CODE); end
        wait_cyc(f + 248);
        checks++; if (vcount - base !== 5) begin errors++; $display("FAIL repeat_count got %0d exp 5", vcount - base); end
        keys = '0;
        tick(80);
        checks++; if (KEY_HELD !== 1'b0) begin errors++; $display("FAIL repeat_release got %b exp 0", KEY_HELD); end
    endtask
`endif

    initial begin
        test_reset;
`ifdef KEYPAD_REPEAT_EN
        test_repeat;
`else
        test_clean_press;
        test_bounce;
        test_multi;
        test_reset_mid_confirm;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cyc %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
